// File: rtl/mic_capture_if.sv
// mic_capture_if
//   Bundles the sample input, the control pulses, the readout stream and the
//   status outputs of mic_capture.
//   slave  : the capture buffer itself
//   master : the upstream decimation chain, the control logic and the readout host
//
// Readout handshake: a sample moves on every rising clk4_8 edge at which
// rd_valid and rd_ready are both high. While rd_valid is high and rd_ready is
// low, rd_data and rd_last hold steady. rd_valid does not depend
// combinationally on rd_ready.
interface mic_capture_if #(
  parameter int DATA_W     = 21,
  parameter int DEPTH_LOG2 = 10
);
  logic [DATA_W-1:0]     smp_data;
  logic                  smp_valid;
  logic                  arm;
  logic                  trig;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  rd_last;
  logic                  busy;
  logic                  done;
  logic [DATA_W-2:0]     peak_mag;
  logic [DEPTH_LOG2-1:0] peak_idx;

  modport slave (
    input  smp_data, smp_valid, arm, trig, rd_ready,
    output rd_data, rd_valid, rd_last, busy, done, peak_mag, peak_idx
  );

  modport master (
    output smp_data, smp_valid, arm, trig, rd_ready,
    input  rd_data, rd_valid, rd_last, busy, done, peak_mag, peak_idx
  );
endinterface

// File: rtl/mic_capture.sv
// mic_capture
//   Trigger-based capture buffer that sits behind the microphone decimation
//   chain. It keeps a ring of DEPTH samples. It freezes a window of PRE_TRIG
//   samples before a ping trigger and DEPTH-PRE_TRIG samples after it. It then
//   streams the window out oldest-first.
//
// Ports
//   clk4_8    : sole clock, rising edge
//   res       : asynchronous active-high reset
//   bus       : mic_capture_if.slave, which carries the samples (smp_data, smp_valid),
//               the arm and trig pulses, the readout stream (rd_data, rd_valid,
//               rd_ready, rd_last), the busy and done status, and peak_mag/peak_idx
//   state_dbg : current FSM state, for observation only
//
// Optional feature: define MIC_CAPTURE_PEAK_EN to track the largest post-trigger
// magnitude and its readout position. Without it, peak_mag and peak_idx are 0.
module mic_capture #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 21,
  parameter int PRE_TRIG   = 64
) (
  input  logic              clk4_8,
  input  logic              res,
  mic_capture_if.slave      bus,
  output logic [2:0]        state_dbg
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] PRE_LEN   = DEPTH_LOG2'(PRE_TRIG);
  localparam logic [DEPTH_LOG2-1:0] PRE_LAST  = DEPTH_LOG2'(PRE_TRIG - 1);
  localparam logic [DEPTH_LOG2-1:0] POST_LAST = DEPTH_LOG2'(DEPTH - PRE_TRIG - 1);
  localparam logic [DEPTH_LOG2:0]   RD_ONE    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   RD_TOTAL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   RD_LASTI  = (DEPTH_LOG2+1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, wr_ptr_nxt, start_ptr, rd_ptr;
  logic [DEPTH_LOG2-1:0] pre_cnt, post_cnt;
  logic [DEPTH_LOG2:0]   rd_cnt;
  logic [DATA_W-1:0]     pf_data, out_data;
  logic                  pf_vld, pf_last, out_vld, out_last;
  logic                  wr_en, trig_hit, pre_full, post_full;
  logic                  rearm, accept, out_load, rd_issue, rd_finish;

  // Control decode
  assign wr_en      = bus.smp_valid &&
                      (state_q == S_PRE || state_q == S_ARMED || state_q == S_POST);
  assign wr_ptr_nxt = wr_ptr + (wr_en ? PTR_ONE : '0);
  assign trig_hit   = (state_q == S_ARMED) && bus.trig;
  assign pre_full   = (state_q == S_PRE) && bus.smp_valid && (pre_cnt == PRE_LAST);
  assign post_full  = (state_q == S_POST) && bus.smp_valid && (post_cnt == POST_LAST);
  assign rearm      = bus.arm && (state_q == S_IDLE || state_q == S_DONE);
  assign accept     = out_vld && bus.rd_ready;
  assign rd_finish  = (state_q == S_DONE) && accept && out_last;

  // The output register can take a new word when it is empty or being drained.
  assign out_load   = !out_vld || bus.rd_ready;
  // Issue a RAM read while the prefetch slot is free or will be vacated this
  // cycle. That keeps one word in flight, so at rd_ready=1 a sample is
  // accepted every cycle.
  assign rd_issue   = (state_q == S_DONE) && !bus.arm && (rd_cnt != RD_TOTAL) &&
                      (!pf_vld || out_load);

  // FSM state register
  always_ff @(posedge clk4_8 or posedge res) begin
    if (res) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.arm)  state_d = S_PRE;
      S_PRE:   if (pre_full) state_d = S_ARMED;
      S_ARMED: if (bus.trig) state_d = S_POST;
      S_POST:  if (post_full) state_d = S_DONE;
      S_DONE: begin
        if (bus.arm)        state_d = S_PRE;
        else if (rd_finish) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pointers and counters
  always_ff @(posedge clk4_8 or posedge res) begin
    if (res) begin
      wr_ptr    <= '0;
      start_ptr <= '0;
      rd_ptr    <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      rd_cnt    <= '0;
    end else if (rearm) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      rd_cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr_nxt;
      if (state_q == S_PRE && bus.smp_valid) pre_cnt <= pre_cnt + PTR_ONE;
      // A sample arriving with the trigger is already counted in wr_ptr_nxt,
      // so it becomes the newest pre-trigger sample.
      if (trig_hit) begin
        start_ptr <= wr_ptr_nxt - PRE_LEN;
        post_cnt  <= '0;
      end
      if (state_q == S_POST && bus.smp_valid) post_cnt <= post_cnt + PTR_ONE;
      if (post_full) begin
        rd_ptr <= start_ptr;
        rd_cnt <= '0;
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        rd_cnt <= rd_cnt + RD_ONE;
      end
    end
  end

  // Sample RAM with a registered read port. Writes and reads happen in
  // disjoint states, so there is no read-during-write case.
  always_ff @(posedge clk4_8) begin
    if (wr_en)    mem[wr_ptr] <= bus.smp_data;
    if (rd_issue) pf_data     <= mem[rd_ptr];
  end

  // Readout: RAM read register (prefetch slot) followed by the output register
  always_ff @(posedge clk4_8 or posedge res) begin
    if (res) begin
      pf_vld   <= 1'b0;
      pf_last  <= 1'b0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else if (rearm || rd_finish) begin
      pf_vld   <= 1'b0;
      pf_last  <= 1'b0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (rd_issue) begin
        pf_vld  <= 1'b1;
        pf_last <= (rd_cnt == RD_LASTI);
      end else if (out_load) begin
        pf_vld  <= 1'b0;
      end
      if (out_load) begin
        out_vld  <= pf_vld;
        out_last <= pf_vld && pf_last;
        if (pf_vld) out_data <= pf_data;
      end
    end
  end

  assign bus.rd_data  = out_data;
  assign bus.rd_valid = out_vld;
  assign bus.rd_last  = out_last;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign state_dbg    = state_q;

`ifdef MIC_CAPTURE_PEAK_EN
  localparam logic [DATA_W-2:0] MAG_ONE = (DATA_W-1)'(1);

  logic [DATA_W-2:0]     smp_mag, peak_mag_q;
  logic [DEPTH_LOG2-1:0] peak_idx_q;

  // |sample| in DATA_W-1 bits. The most negative code has no positive
  // counterpart, so it saturates to all ones.
  always_comb begin
    smp_mag = bus.smp_data[DATA_W-2:0];
    if (bus.smp_data[DATA_W-1]) begin
      if (bus.smp_data[DATA_W-2:0] == '0) smp_mag = '1;
      else                                smp_mag = ~bus.smp_data[DATA_W-2:0] + MAG_ONE;
    end
  end

  // Strictly-greater update, so the first occurrence of a tie is kept.
  always_ff @(posedge clk4_8 or posedge res) begin
    if (res) begin
      peak_mag_q <= '0;
      peak_idx_q <= '0;
    end else if (rearm) begin
      peak_mag_q <= '0;
      peak_idx_q <= '0;
    end else if (state_q == S_POST && bus.smp_valid && smp_mag > peak_mag_q) begin
      peak_mag_q <= smp_mag;
      peak_idx_q <= PRE_LEN + post_cnt;
    end
  end

  assign bus.peak_mag = peak_mag_q;
  assign bus.peak_idx = peak_idx_q;
`else
  assign bus.peak_mag = '0;
  assign bus.peak_idx = '0;
`endif
endmodule

// File: tb/tb_mic_capture.sv
// tb_mic_capture
//   Bench for mic_capture with DEPTH_LOG2=4, PRE_TRIG=4. The reference model
//   records every sample fed since arm. It slices out the expected window
//   around the first honoured trigger, and it computes the expected peak
//   directly from the post-trigger samples.
module tb_mic_capture;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int DATA_W     = 21;
  localparam int PRE_TRIG   = 4;
  localparam int POST_LEN   = DEPTH - PRE_TRIG;
  localparam int MAG_MAX    = (1 << (DATA_W - 1)) - 1;

  logic       clk;
  logic       res;
  logic [2:0] state_dbg;

  mic_capture_if #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  mic_capture #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_W    (DATA_W),
    .PRE_TRIG  (PRE_TRIG)
  ) dut (
    .clk4_8   (clk),
    .res      (res),
    .bus      (bus.slave),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int                n_checks = 0;
  int                n_errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] fed[$];
  int                exp_peak_mag;
  int                exp_peak_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: window and peak derived from the fed sample list
  function automatic int mag_of(input logic [DATA_W-1:0] v);
    int sv;
    sv = v[DATA_W-1] ? int'(v) - (1 << DATA_W) : int'(v);
    if (sv < 0) sv = -sv;
    if (sv > MAG_MAX) sv = MAG_MAX;
    return sv;
  endfunction

  task automatic build_model(input int k);
    int m;
    exp_q.delete();
    for (int i = k - PRE_TRIG + 1; i <= k + POST_LEN; i++) exp_q.push_back(fed[i]);
    exp_peak_mag = 0;
    exp_peak_idx = 0;
`ifdef MIC_CAPTURE_PEAK_EN
    for (int j = 0; j < POST_LEN; j++) begin
      m = mag_of(fed[k + 1 + j]);
      if (m > exp_peak_mag) begin
        exp_peak_mag = m;
        exp_peak_idx = PRE_TRIG + j;
      end
    end
`else
    m = 0;
`endif
  endtask

  // Sample generator: 0 = counting, 1 = random, 2 = peak pattern
  function automatic logic [DATA_W-1:0] gen(input int mode, input int base, input int i, input int k);
    if (mode == 0) return DATA_W'(base + i);
    if (mode == 1) return DATA_W'($urandom);
    if (i <= k) return DATA_W'(base + i);
    if (i - k - 1 == 3) return DATA_W'(1 << (DATA_W - 1));
    return DATA_W'(5);
  endfunction

  // Drivers (inputs change on the falling edge, outputs sampled there too)
  task automatic pulse_arm();
    bus.arm = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0;
  endtask

  task automatic feed_one(input logic [DATA_W-1:0] v, input bit t, input int gap);
    bus.smp_data  = v;
    bus.smp_valid = 1'b1;
    bus.trig      = t;
    @(negedge clk);
    bus.smp_valid = 1'b0;
    bus.trig      = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Arm (optionally), feed samples up to the end of the window, then check the
  // freeze, the readout latency, that late samples are dropped, and the peak.
  task automatic capture(input bit do_arm, input int mode, input int base,
                         input int ign_k, input int k, input bit rnd_gap);
    int n_total;
    int k_eff;
    logic [DATA_W-1:0] v;
    fed.delete();
    bus.rd_ready = 1'b0;
    if (do_arm) pulse_arm();
    check("busy_after_arm", 32'(bus.busy), 32'd1);
    check("peak_mag_cleared", 32'(bus.peak_mag), 32'd0);
    check("peak_idx_cleared", 32'(bus.peak_idx), 32'd0);
    k_eff = (ign_k >= PRE_TRIG) ? ign_k : k;
    n_total = k_eff + POST_LEN + 1;
    for (int i = 0; i < n_total; i++) begin
      v = gen(mode, base, i, k_eff);
      fed.push_back(v);
      if (i == n_total - 1) feed_one(v, (i == k) || (i == ign_k), 0);
      else feed_one(v, (i == k) || (i == ign_k), rnd_gap ? int'($urandom_range(0, 3)) : 3);
      if (i < n_total - 1) check("busy_capturing", 32'(bus.busy), 32'd1);
    end
    build_model(k_eff);
    check("done_on_freeze", 32'(bus.done), 32'd1);
    check("rd_valid_lat0", 32'(bus.rd_valid), 32'd0);
    @(negedge clk);
    check("rd_valid_lat1", 32'(bus.rd_valid), 32'd0);
    @(negedge clk);
    check("rd_valid_lat2", 32'(bus.rd_valid), 32'd1);
    check("first_rd_data", 32'(bus.rd_data), 32'(exp_q[0]));
    // Samples and a trigger arriving while frozen are ignored.
    feed_one(DATA_W'($urandom), 1'b1, 0);
    feed_one(DATA_W'($urandom), 1'b0, 0);
    check("peak_mag", 32'(bus.peak_mag), 32'(exp_peak_mag));
    check("peak_idx", 32'(bus.peak_idx), 32'(exp_peak_idx));
  endtask

  // Readout consumer. rmode selects rd_ready: 0 = always 1, 1 = toggling,
  // 2 = random. It stops after max_acc accepts; the last accept takes place
  // on the following rising edge.
  task automatic drain(input int rmode, input int max_acc);
    int acc;
    int cyc;
    bit stalled;
    logic [DATA_W-1:0] held;
    logic [DATA_W-1:0] e;
    acc = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (acc < max_acc && cyc < 400) begin
      case (rmode)
        0:       bus.rd_ready = 1'b1;
        1:       bus.rd_ready = (cyc % 2 == 0);
        default: bus.rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        check("stall_valid", 32'(bus.rd_valid), 32'd1);
        check("stall_data", 32'(bus.rd_data), 32'(held));
      end
      if (bus.rd_valid && bus.rd_ready) begin
        e = exp_q.pop_front();
        check("rd_data", 32'(bus.rd_data), 32'(e));
        check("rd_last", 32'(bus.rd_last), 32'(exp_q.size() == 0));
        acc++;
        stalled = 1'b0;
      end else begin
        stalled = bus.rd_valid;
        held    = bus.rd_data;
      end
      cyc++;
      if (acc < max_acc) @(negedge clk);
    end
    if (acc < max_acc) check("drain_timeout", 32'(acc), 32'(max_acc));
  endtask

  task automatic finish_readout();
    @(negedge clk);
    bus.rd_ready = 1'b0;
    check("rd_valid_after_last", 32'(bus.rd_valid), 32'd0);
    check("busy_after_last", 32'(bus.busy), 32'd0);
    check("done_after_last", 32'(bus.done), 32'd0);
    check("window_consumed", 32'(exp_q.size()), 32'd0);
    check("peak_mag_held", 32'(bus.peak_mag), 32'(exp_peak_mag));
    check("peak_idx_held", 32'(bus.peak_idx), 32'(exp_peak_idx));
  endtask

  // Main sequence
  initial begin
    int k;
    res           = 1'b1;
    bus.smp_data  = '0;
    bus.smp_valid = 1'b0;
    bus.arm       = 1'b0;
    bus.trig      = 1'b0;
    bus.rd_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_last", 32'(bus.rd_last), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_peak_mag", 32'(bus.peak_mag), 32'd0);
    check("rst_peak_idx", 32'(bus.peak_idx), 32'd0);
    res = 1'b0;
    @(negedge clk);

    // Basic capture: trigger with sample 10 gives a readout of 7..22.
    capture(1'b1, 0, 1, -1, 9, 1'b0);
    drain(0, DEPTH);
    finish_readout();

    // A trigger during PRE (sample 2) is ignored; the later one at 30 gives 27..42.
    capture(1'b1, 0, 1, 1, 29, 1'b0);
    drain(1, DEPTH);
    finish_readout();

    // Abort mid-readout by re-arming, then capture 107..122.
    capture(1'b1, 0, 1, -1, 9, 1'b0);
    drain(0, 5);
    @(negedge clk);
    bus.rd_ready = 1'b0;
    bus.arm      = 1'b1;
    @(negedge clk);
    bus.arm      = 1'b0;
    check("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd1);
    capture(1'b0, 0, 100, -1, 10, 1'b0);
    drain(0, DEPTH);
    finish_readout();

    // Asynchronous reset in the middle of POST.
    pulse_arm();
    for (int i = 0; i < 10; i++) feed_one(DATA_W'(200 + i), i == 6, 1);
    check("busy_pre_reset", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #2;
    res = 1'b1;
    #1;
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    check("async_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("async_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    res = 1'b0;
    for (int i = 0; i < 8; i++) begin
      feed_one(DATA_W'(300 + i), 1'b1, 1);
      check("idle_after_rst_busy", 32'(bus.busy), 32'd0);
      check("idle_after_rst_valid", 32'(bus.rd_valid), 32'd0);
    end

    // Peak pattern: most negative sample at post index 3, +5 elsewhere.
    capture(1'b1, 2, 1, -1, 5, 1'b0);
    drain(0, DEPTH);
    finish_readout();

    // Randomized captures: random data, trigger position, gaps and back-pressure.
    for (int r = 0; r < 6; r++) begin
      k = int'($urandom_range(PRE_TRIG, 20));
      capture(1'b1, 1, 0, int'($urandom_range(0, PRE_TRIG - 1)), k, 1'b1);
      drain(2, DEPTH);
      finish_readout();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
